arbiter_rr_mux: RTL and testbench

- Round-robin scheduler that shares the 8-bit two-input mux path between two upstream first-word-fall-through FIFOs.
- Issues pop strobes to the upstream FIFOs and drives the lane select.
- Emits registered data_out/valid_out toward a downstream FIFO and honours that FIFO's almost_full backpressure.
- A per-lane burst limit bounds how long one lane can hold the path while the other lane waits.

---
 rtl/arbiter_rr_mux_pkg.sv | 15 +
 rtl/arbiter_rr_grant.sv | 53 +++++
 rtl/arbiter_rr_mux.sv | 117 +++++++++++
 tb/tb_arbiter_rr_mux.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_rr_mux_pkg.sv
// Shared definitions for the two-lane round-robin scheduler.
//   state_t : FSM encoding (RESET / IDLE / ACTIVE)
//   LANE0/1 : lane identifiers used for grant and select values
package arbiter_rr_mux_pkg;

  typedef enum logic [1:0] {
    RESET  = 2'b00,
    IDLE   = 2'b01,
    ACTIVE = 2'b10
  } state_t;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/arbiter_rr_grant.sv
// Combinational round-robin grant decision with a per-lane burst limit.
// Ports:
//   i_cur        : lane currently holding the path
//   i_burst_cnt  : consecutive grants already given to i_cur
//   i_empty0/1   : upstream FIFO empty flags
//   i_en         : arbitration allowed this cycle (ACTIVE and no backpressure)
//   o_grant_valid: a pop is issued this cycle
//   o_grant_lane : lane receiving the pop
//   o_next_cnt   : burst counter value after this grant
module arbiter_rr_grant
  import arbiter_rr_mux_pkg::*;
#(
  parameter int BURST = 4,
  parameter int CNT_W = 3
) (
  input  logic             i_cur,
  input  logic [CNT_W-1:0] i_burst_cnt,
  input  logic             i_empty0,
  input  logic             i_empty1,
  input  logic             i_en,
  output logic             o_grant_valid,
  output logic             o_grant_lane,
  output logic [CNT_W-1:0] o_next_cnt
);

  logic w_cur_empty;
  logic w_oth_empty;
  logic w_below_burst;

  assign w_cur_empty   = (i_cur == LANE1) ? i_empty1 : i_empty0;
  assign w_oth_empty   = (i_cur == LANE1) ? i_empty0 : i_empty1;
  assign w_below_burst = (i_burst_cnt < CNT_W'(BURST));

  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_lane  = i_cur;
    o_next_cnt    = i_burst_cnt;
    if (i_en) begin
      // A lone non-empty lane keeps the path past the burst limit; its
      // counter saturates so a later switch decision stays correct.
      if (!w_cur_empty && (w_below_burst || w_oth_empty)) begin
        o_grant_valid = 1'b1;
        o_grant_lane  = i_cur;
        o_next_cnt    = w_below_burst ? (i_burst_cnt + CNT_W'(1)) : CNT_W'(BURST);
      end else if (!w_oth_empty) begin
        o_grant_valid = 1'b1;
        o_grant_lane  = ~i_cur;
        o_next_cnt    = CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/arbiter_rr_mux.sv
// Round-robin scheduler sharing one data path between two first-word-fall-
// through FIFOs, forwarding registered words to a downstream FIFO.
// Ports:
//   clk, reset_L          : clock, asynchronous active-low reset
//   fifo0/1_empty, _data  : upstream FIFO status and head word
//   dest_almost_full      : downstream backpressure
//   fifo0/1_pop           : consume the upstream head at this clock edge
//   valid_out, data_out   : forwarded word (one cycle after its pop)
//   sel_out               : lane that sourced data_out
//   idle_out              : FSM is in IDLE
//   dbg_state             : raw FSM state for observation
//
// Handshake: a pop strobe high at a rising edge consumes the head word of
// that lane at that edge; the same edge registers the word, so valid_out is
// high for exactly the following cycle. No pop is issued while
// dest_almost_full is high, and never to an empty lane.
module arbiter_rr_mux
  import arbiter_rr_mux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BURST  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              fifo0_empty,
  input  logic              fifo1_empty,
  input  logic [DATA_W-1:0] fifo0_data,
  input  logic [DATA_W-1:0] fifo1_data,
  input  logic              dest_almost_full,
  output logic              fifo0_pop,
  output logic              fifo1_pop,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              sel_out,
  output logic              idle_out,
  output logic [1:0]        dbg_state
);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_cur;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic               r_valid;
  logic [DATA_W-1:0]  r_data;
  logic               r_sel;

  logic               w_en;
  logic               w_grant_valid;
  logic               w_grant_lane;
  logic [CNT_W-1:0]   w_next_cnt;

  assign w_en = (r_state == ACTIVE) && !dest_almost_full;

  arbiter_rr_grant #(
    .BURST (BURST),
    .CNT_W (CNT_W)
  ) u_grant (
    .i_cur         (r_cur),
    .i_burst_cnt   (r_burst_cnt),
    .i_empty0      (fifo0_empty),
    .i_empty1      (fifo1_empty),
    .i_en          (w_en),
    .o_grant_valid (w_grant_valid),
    .o_grant_lane  (w_grant_lane),
    .o_next_cnt    (w_next_cnt)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RESET:  w_next_state = IDLE;
      IDLE:   if ((!fifo0_empty || !fifo1_empty) && !dest_almost_full) w_next_state = ACTIVE;
      ACTIVE: if ((fifo0_empty && fifo1_empty) || dest_almost_full)    w_next_state = IDLE;
      default: w_next_state = RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= RESET;
      r_cur       <= LANE0;
      r_burst_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      // cur/burst_cnt only move on a grant, so a backpressure stall resumes
      // the same burst where it left off.
      if (w_grant_valid) begin
        r_cur       <= w_grant_lane;
        r_burst_cnt <= w_next_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= LANE0;
    end else begin
      r_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_data <= (w_grant_lane == LANE1) ? fifo1_data : fifo0_data;
        r_sel  <= w_grant_lane;
      end
    end
  end

  assign fifo0_pop = w_grant_valid && (w_grant_lane == LANE0);
  assign fifo1_pop = w_grant_valid && (w_grant_lane == LANE1);
  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign sel_out   = r_sel;
  assign idle_out  = (r_state == IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_arbiter_rr_mux.sv
module tb_arbiter_rr_mux;
  import arbiter_rr_mux_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       reset_L;
  logic       fifo0_empty, fifo1_empty;
  logic [7:0] fifo0_data, fifo1_data;
  logic       dest_almost_full;
  logic       fifo0_pop, fifo1_pop;
  logic       valid_out;
  logic [7:0] data_out;
  logic       sel_out;
  logic       idle_out;
  logic [1:0] dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  arbiter_rr_mux #(.DATA_W(8), .BURST(4), .CNT_W(3)) dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .fifo0_empty      (fifo0_empty),
    .fifo1_empty      (fifo1_empty),
    .fifo0_data       (fifo0_data),
    .fifo1_data       (fifo1_data),
    .dest_almost_full (dest_almost_full),
    .fifo0_pop        (fifo0_pop),
    .fifo1_pop        (fifo1_pop),
    .valid_out        (valid_out),
    .data_out         (data_out),
    .sel_out          (sel_out),
    .idle_out         (idle_out),
    .dbg_state        (dbg_state)
  );

  // ---------------- state of the bench ----------------
  logic [7:0] f0_q[$];
  logic [7:0] f1_q[$];
  logic [8:0] exp_q[$];      // {sel, data} expected on valid_out
  logic       exp_pop_q[$];  // expected pop lane order
  logic       p0, p1;        // pop strobes seen in the current cycle
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_pops   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic refresh();
    fifo0_empty = (f0_q.size() == 0);
    fifo1_empty = (f1_q.size() == 0);
    fifo0_data  = (f0_q.size() != 0) ? f0_q[0] : 8'hEE;
    fifo1_data  = (f1_q.size() != 0) ? f1_q[0] : 8'hEE;
  endtask

  // Upstream FIFO model: a strobe present at the rising edge (and not
  // cancelled by reset) consumes the head word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset_L) begin
        if (p0 && f0_q.size() != 0) void'(f0_q.pop_front());
        if (p1 && f1_q.size() != 0) void'(f1_q.pop_front());
      end
      p0 = 1'b0;
      p1 = 1'b0;
      refresh();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [8:0] e;
    logic       el;
    p0 = 1'b0;
    p1 = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_L) begin
        if (valid_out) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", {23'd0, sel_out, data_out}, 32'h1FF);
          end else begin
            e = exp_q.pop_front();
            check("word_out", {23'd0, sel_out, data_out}, {23'd0, e});
          end
        end
        check("single_pop", {31'd0, fifo0_pop && fifo1_pop}, 32'd0);
        if (fifo0_pop || fifo1_pop) begin
          n_pops++;
          check("pop_nonempty", {31'd0, fifo1_pop ? (f1_q.size() != 0) : (f0_q.size() != 0)}, 32'd1);
          if (exp_pop_q.size() == 0) begin
            check("unexpected_pop", {31'd0, fifo1_pop}, 32'h2);
          end else begin
            el = exp_pop_q.pop_front();
            check("pop_lane", {31'd0, fifo1_pop}, {31'd0, el});
          end
        end
        p0 = fifo0_pop;
        p1 = fifo1_pop;
      end else begin
        p0 = 1'b0;
        p1 = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold_reset();
    @(negedge clk);
    #2;
    reset_L = 1'b0;
    f0_q.delete();
    f1_q.delete();
    exp_q.delete();
    exp_pop_q.delete();
    n_pops = 0;
    refresh();
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    reset_L = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] base0, input int n0, input logic [7:0] base1, input int n1);
    for (int i = 0; i < n0; i++) f0_q.push_back(base0 + 8'(i));
    for (int i = 0; i < n1; i++) f1_q.push_back(base1 + 8'(i));
    refresh();
  endtask

  task automatic expect_word(input logic lane, input logic [7:0] d);
    exp_q.push_back({lane, d});
    exp_pop_q.push_back(lane);
  endtask

  task automatic wait_pops(input string name, input int target);
    int n = 0;
    while (n_pops < target && n < 100) begin
      step();
      n++;
    end
    check(name, n_pops, target);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp_pop_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check({name, "_drain"}, exp_q.size() + exp_pop_q.size(), 0);
    step();
    step();
    check({name, "_idle"}, {31'd0, idle_out}, 32'd1);
    check({name, "_valid_low"}, {31'd0, valid_out}, 32'd0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    reset_L          = 1'b1;
    dest_almost_full = 1'b0;
    refresh();
    #1 reset_L = 1'b0;

    // Reset: head 5A present, nothing may leave the block.
    f0_q.push_back(8'h5A);
    refresh();
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_pop", {30'd0, fifo1_pop, fifo0_pop}, 32'd0);
      check("rst_valid", {31'd0, valid_out}, 32'd0);
      check("rst_data", {24'd0, data_out}, 32'd0);
      check("rst_idle", {31'd0, idle_out}, 32'd0);
    end

    // Single lane: A1..A3 on lane 0 only.
    f0_q.delete();
    load(8'hA1, 3, 8'h00, 0);
    expect_word(LANE0, 8'hA1);
    expect_word(LANE0, 8'hA2);
    expect_word(LANE0, 8'hA3);
    release_reset();
    step();  // cycle 1
    check("sl_idle_c1", {31'd0, idle_out}, 32'd1);
    check("sl_nopop_c1", {31'd0, fifo0_pop}, 32'd0);
    step();  // cycle 2
    check("sl_state_c2", {30'd0, dbg_state}, {30'd0, ACTIVE});
    check("sl_pop_c2", {31'd0, fifo0_pop}, 32'd1);
    step();  // cycle 3
    check("sl_pop_c3", {31'd0, fifo0_pop}, 32'd1);
    check("sl_valid_c3", {31'd0, valid_out}, 32'd1);
    step();  // cycle 4
    check("sl_pop_c4", {31'd0, fifo0_pop}, 32'd1);
    step();  // cycle 5
    check("sl_nopop_c5", {31'd0, fifo0_pop}, 32'd0);
    check("sl_valid_c5", {31'd0, valid_out}, 32'd1);
    drain("single");

    // Fairness: 6 words per lane, burst of 4.
    hold_reset();
    load(8'h00, 6, 8'h10, 6);
    for (int i = 0; i < 4; i++) expect_word(LANE0, 8'h00 + 8'(i));
    for (int i = 0; i < 4; i++) expect_word(LANE1, 8'h10 + 8'(i));
    expect_word(LANE0, 8'h04);
    expect_word(LANE0, 8'h05);
    expect_word(LANE1, 8'h14);
    expect_word(LANE1, 8'h15);
    release_reset();
    drain("fair");

    // Backpressure after the 2nd lane-0 pop, held for 2 cycles.
    hold_reset();
    load(8'h20, 6, 8'h30, 6);
    for (int i = 0; i < 4; i++) expect_word(LANE0, 8'h20 + 8'(i));
    for (int i = 0; i < 4; i++) expect_word(LANE1, 8'h30 + 8'(i));
    expect_word(LANE0, 8'h24);
    expect_word(LANE0, 8'h25);
    expect_word(LANE1, 8'h34);
    expect_word(LANE1, 8'h35);
    release_reset();
    wait_pops("bp_reach2", 2);
    @(posedge clk);
    #2 dest_almost_full = 1'b1;
    step();
    check("bp_nopop_a", {30'd0, fifo1_pop, fifo0_pop}, 32'd0);
    step();
    check("bp_nopop_b", {30'd0, fifo1_pop, fifo0_pop}, 32'd0);
    check("bp_valid_b", {31'd0, valid_out}, 32'd0);
    @(posedge clk);
    #2 dest_almost_full = 1'b0;
    step();
    check("bp_bubble", {30'd0, fifo1_pop, fifo0_pop}, 32'd0);
    check("bp_idle", {31'd0, idle_out}, 32'd1);
    check("bp_valid_c", {31'd0, valid_out}, 32'd0);
    step();
    check("bp_resume_lane0", {30'd0, fifo1_pop, fifo0_pop}, 32'd1);
    check("bp_valid_d", {31'd0, valid_out}, 32'd0);
    drain("bp");

    // Mid-burst empty: lane 0 has 2, lane 1 has 5; no gap at the switch.
    hold_reset();
    load(8'h40, 2, 8'h50, 5);
    expect_word(LANE0, 8'h40);
    expect_word(LANE0, 8'h41);
    for (int i = 0; i < 5; i++) expect_word(LANE1, 8'h50 + 8'(i));
    release_reset();
    wait_pops("mb_first", 1);
    for (int i = 0; i < 7; i++) begin
      check("mb_no_gap", {31'd0, fifo0_pop || fifo1_pop}, 32'd1);
      if (i < 6) step();
    end
    drain("midburst");

    // Async reset mid-stream during the fairness pattern.
    hold_reset();
    load(8'h00, 6, 8'h10, 6);
    for (int i = 0; i < 4; i++) expect_word(LANE0, 8'h00 + 8'(i));
    exp_q.push_back({LANE1, 8'h10});  // 8'h11 is popped but dropped by reset
    exp_pop_q.push_back(LANE1);
    exp_pop_q.push_back(LANE1);
    release_reset();
    wait_pops("ar_reach6", 6);
    @(posedge clk);
    #3 reset_L = 1'b0;
    #1;
    check("ar_valid_clr", {31'd0, valid_out}, 32'd0);
    check("ar_data_clr", {24'd0, data_out}, 32'd0);
    check("ar_pop_clr", {30'd0, fifo1_pop, fifo0_pop}, 32'd0);
    check("ar_state", {30'd0, dbg_state}, {30'd0, RESET});
    check("ar_words_left", f0_q.size() + f1_q.size(), 6);
    expect_word(LANE0, 8'h04);
    expect_word(LANE0, 8'h05);
    for (int i = 2; i < 6; i++) expect_word(LANE1, 8'h10 + 8'(i));
    @(negedge clk);
    release_reset();
    drain("areset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
